// File: rtl/prim_ram_adapter_pkg.sv
// -----------------------------------------------------------------------------
// prim_ram_adapter_pkg
//
// Shared definitions for the single-port RAM request adapter and its response
// queue.
//   RAM_WIDTH_DEFAULT  default data width of the attached RAM
//   RSP_DEPTH_DEFAULT  default number of response queue entries
//   rsp_kind_e         kind of an outstanding request (read or write)
//   rsp_entry_t        layout of one response queue entry {rdata, write}
//   is_pow2()          helper used to describe legal queue depths
// -----------------------------------------------------------------------------
package prim_ram_adapter_pkg;

    localparam int unsigned RAM_WIDTH_DEFAULT = 32;
    localparam int unsigned RSP_DEPTH_DEFAULT = 2;

    typedef enum logic {
        RSP_READ  = 1'b0,
        RSP_WRITE = 1'b1
    } rsp_kind_e;

    // One response queue entry. The write flag sits in the LSB so that the
    // queue word is simply {rdata, write}; the top keeps the same layout when
    // Width differs from the default.
    typedef struct packed {
        logic [RAM_WIDTH_DEFAULT-1:0] rdata;
        logic                         write;
    } rsp_entry_t;

    function automatic bit is_pow2(input int unsigned value);
        return (value != 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage : prim_ram_adapter_pkg

// File: rtl/prim_fifo_sync.sv
// -----------------------------------------------------------------------------
// prim_fifo_sync
//
// Small synchronous FIFO with a combinational head (first-word fall-through).
// The head entry stays stable while it is not popped. Storage is not reset;
// only pointers and the occupancy count are.
//
// Ports
//   clk_i     clock, all state on the rising edge
//   rst_ni    asynchronous active-low reset
//   wvalid_i  push request (ignored when full and not popping)
//   wdata_i   push data
//   rready_i  pop request (ignored when empty)
//   rvalid_o  queue not empty
//   rdata_o   head entry
//   count_o   number of stored entries, 0..Depth
// -----------------------------------------------------------------------------
module prim_fifo_sync #(
    parameter  int unsigned Width = 33,
    parameter  int unsigned Depth = 2,     // power of two, >= 2
    localparam int unsigned PtrW  = $clog2(Depth),
    localparam int unsigned CntW  = $clog2(Depth) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wvalid_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             rready_i,
    output logic             rvalid_o,
    output logic [Width-1:0] rdata_o,
    output logic [CntW-1:0]  count_o
);

    logic [PtrW-1:0]  wptr_reg;
    logic [PtrW-1:0]  wptr_next;
    logic [PtrW-1:0]  rptr_reg;
    logic [PtrW-1:0]  rptr_next;
    logic [CntW-1:0]  count_reg;
    logic [CntW-1:0]  count_next;
    logic             push_en;
    logic             pop_en;
    logic             empty;
    logic             full;
    logic [Width-1:0] storage_reg [Depth];

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CntW'(Depth));
    assign pop_en  = rready_i & ~empty;
    // A push into a full queue is only legal when the head leaves this cycle.
    assign push_en = wvalid_i & (~full | pop_en);

    // Pointers wrap naturally because Depth is a power of two.
    assign wptr_next  = push_en ? wptr_reg + 1'b1 : wptr_reg;
    assign rptr_next  = pop_en  ? rptr_reg + 1'b1 : rptr_reg;
    assign count_next = count_reg + CntW'(push_en) - CntW'(pop_en);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            wptr_reg  <= wptr_next;
            rptr_reg  <= rptr_next;
            count_reg <= count_next;
        end
    end

    // One register bank per entry, written only when the write pointer
    // selects it. No reset: contents are only visible while count says so.
    for (genvar gi = 0; gi < Depth; gi++) begin : gen_entry
        always_ff @(posedge clk_i) begin
            if (push_en && (wptr_reg == PtrW'(gi))) begin
                storage_reg[gi] <= wdata_i;
            end
        end
    end

    assign rvalid_o = ~empty;
    assign rdata_o  = storage_reg[rptr_reg];
    assign count_o  = count_reg;

endmodule : prim_fifo_sync

// File: rtl/prim_ram_1p_req_adapter.sv
// -----------------------------------------------------------------------------
// prim_ram_1p_req_adapter
//
// Adapts a valid/ready request + response host interface onto a single-port
// RAM with a fixed read latency of one cycle. Every accepted request (read or
// write) produces exactly one response, returned in request order through a
// small response queue. Requests are only accepted when a queue slot is
// guaranteed for the resulting response, so the queue can never overflow and
// the RAM never needs to be stalled.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_valid_i/ready_o    request handshake
//   req_write_i            1 = write, 0 = read
//   req_addr_i             word address (Aw bits)
//   req_wdata_i/wmask_i    write data and per-bit write enable
//   rsp_valid_o/ready_i    response handshake
//   rsp_rdata_o            read data (0 for write acks)
//   rsp_write_o            response is a write ack
//   mem_req_o .. wmask_o   RAM request port (pass-through of req_*)
//   mem_rvalid_i/rdata_i   RAM read return, one cycle after the read
//   idle_o                 nothing in flight and queue empty
//   protocol_err_o         sticky: RAM read return missing or unexpected
// -----------------------------------------------------------------------------
module prim_ram_1p_req_adapter
    import prim_ram_adapter_pkg::*;
#(
    parameter  int unsigned Width    = RAM_WIDTH_DEFAULT,
    parameter  int unsigned Depth    = 128,
    parameter  int unsigned RspDepth = RSP_DEPTH_DEFAULT,  // power of two, >= 2
    localparam int unsigned Aw       = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_write_i,
    input  logic [Aw-1:0]    req_addr_i,
    input  logic [Width-1:0] req_wdata_i,
    input  logic [Width-1:0] req_wmask_i,

    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [Width-1:0] rsp_rdata_o,
    output logic             rsp_write_o,

    output logic             mem_req_o,
    output logic             mem_write_o,
    output logic [Aw-1:0]    mem_addr_o,
    output logic [Width-1:0] mem_wdata_o,
    output logic [Width-1:0] mem_wmask_o,
    input  logic             mem_rvalid_i,
    input  logic [Width-1:0] mem_rdata_i,

    output logic             idle_o,
    output logic             protocol_err_o
);

    localparam int unsigned CntW   = $clog2(RspDepth) + 1;
    localparam int unsigned OccW   = CntW + 1;
    // Queue word is rsp_entry_t with rdata stretched to Width bits.
    localparam int unsigned EntryW = Width + $bits(rsp_entry_t) - RAM_WIDTH_DEFAULT;

    // ---------------------------------------------------------------------
    // Request side
    // ---------------------------------------------------------------------
    logic              accept;
    logic              pop;
    logic              push;
    logic [CntW-1:0]   rsp_count;
    logic [OccW-1:0]   occupancy;

    // Pending request: the one accepted last cycle whose response enters the
    // queue at the end of this cycle.
    logic              pending_valid_reg;
    logic              pending_valid_next;
    rsp_kind_e         pending_kind_reg;
    rsp_kind_e         pending_kind_next;
    logic              read_pending;

    logic              protocol_err_reg;
    logic              protocol_err_next;

    logic [Width-1:0]  push_rdata;
    logic [EntryW-1:0] push_entry;
    logic [EntryW-1:0] head_entry;
    logic              fifo_rvalid;

    // Slots already promised (stored + in flight), less the one leaving this
    // cycle. Counting the pop keeps full throughput with rsp_ready_i high.
    assign occupancy   = OccW'(rsp_count) + OccW'(pending_valid_reg) - OccW'(pop);
    assign req_ready_o = (occupancy < OccW'(RspDepth));
    assign accept      = req_valid_i & req_ready_o;

    // The RAM sees the request in the same cycle it is accepted.
    assign mem_req_o   = accept;
    assign mem_write_o = req_write_i;
    assign mem_addr_o  = req_addr_i;
    assign mem_wdata_o = req_wdata_i;
    assign mem_wmask_o = req_wmask_i;

    // ---------------------------------------------------------------------
    // Pending tracking and RAM return checking
    // ---------------------------------------------------------------------
    assign read_pending = pending_valid_reg & (pending_kind_reg == RSP_READ);

    always_comb begin
        pending_valid_next = accept;
        pending_kind_next  = pending_kind_reg;
        if (accept) begin
            pending_kind_next = req_write_i ? RSP_WRITE : RSP_READ;
        end
        // A return with no read outstanding, or a read with no return, is a
        // violation of the one-cycle read latency contract.
        protocol_err_next = protocol_err_reg | (mem_rvalid_i != read_pending);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_valid_reg <= 1'b0;
            pending_kind_reg  <= RSP_READ;
            protocol_err_reg  <= 1'b0;
        end else begin
            pending_valid_reg <= pending_valid_next;
            pending_kind_reg  <= pending_kind_next;
            protocol_err_reg  <= protocol_err_next;
        end
    end

    assign protocol_err_o = protocol_err_reg;

    // ---------------------------------------------------------------------
    // Response queue
    // ---------------------------------------------------------------------
    // Write acks carry zero data; a read whose return went missing also
    // pushes zero rather than whatever sits on mem_rdata_i.
    assign push       = pending_valid_reg;
    assign push_rdata = (read_pending && mem_rvalid_i) ? mem_rdata_i : '0;
    assign push_entry = {push_rdata, (pending_kind_reg == RSP_WRITE)};

    // Pop only when the queue holds an entry, so an empty queue never sees a
    // simultaneous push and pop (no bypass path).
    assign pop = fifo_rvalid & rsp_ready_i;

    prim_fifo_sync #(
        .Width (EntryW),
        .Depth (RspDepth)
    ) u_rsp_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .wvalid_i (push),
        .wdata_i  (push_entry),
        .rready_i (pop),
        .rvalid_o (fifo_rvalid),
        .rdata_o  (head_entry),
        .count_o  (rsp_count)
    );

    assign rsp_valid_o = fifo_rvalid;
    assign rsp_rdata_o = head_entry[EntryW-1:1];
    assign rsp_write_o = head_entry[0];

    assign idle_o = ~pending_valid_reg & (rsp_count == '0);

endmodule : prim_ram_1p_req_adapter

// File: tb/tb_prim_ram_1p_req_adapter.sv
module tb_prim_ram_1p_req_adapter;

    localparam int W  = 32;
    localparam int D  = 128;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [W-1:0]  req_wdata = '0;
    logic [W-1:0]  req_wmask = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [W-1:0]  rsp_rdata;
    logic          rsp_write;
    logic          mem_req;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_wdata;
    logic [W-1:0]  mem_wmask;
    logic          mem_rvalid;
    logic [W-1:0]  mem_rdata;
    logic          idle;
    logic          protocol_err;

    always #5 clk = ~clk;

    prim_ram_1p_req_adapter #(
        .Width    (W),
        .Depth    (D),
        .RspDepth (2)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_write_i    (req_write),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .req_wmask_i    (req_wmask),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_rdata_o    (rsp_rdata),
        .rsp_write_o    (rsp_write),
        .mem_req_o      (mem_req),
        .mem_write_o    (mem_write),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_wmask_o    (mem_wmask),
        .mem_rvalid_i   (mem_rvalid),
        .mem_rdata_i    (mem_rdata),
        .idle_o         (idle),
        .protocol_err_o (protocol_err)
    );

    // ---------------- RAM model: one-cycle read latency -----------------
    logic [W-1:0] ram [D];
    logic         model_rvalid;
    logic [W-1:0] model_rdata;
    logic         force_rvalid = 1'b0;
    logic         suppress_rvalid = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_rvalid <= 1'b0;
            model_rdata  <= '0;
        end else begin
            model_rvalid <= mem_req && !mem_write;
            if (mem_req && !mem_write) model_rdata <= ram[mem_addr];
            if (mem_req && mem_write)
                ram[mem_addr] <= (ram[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
        end
    end

    assign mem_rvalid = (model_rvalid & ~suppress_rvalid) | force_rvalid;
    assign mem_rdata  = model_rdata;

    // ---------------- Checking infrastructure ---------------------------
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic         w;
        logic [W-1:0] d;
        int           t;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] ref_mem [D];
    logic         chk_lat = 1'b0;
    int           rsp_seen = 0;
    logic [W-1:0] last_rdata = '0;
    exp_t         mon_e;
    int           s_idx = 0;
    int           s_stalls = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Response monitor: pops the scoreboard on every response handshake.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            check("rsp_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("rsp_write", 64'(rsp_write), 64'(mon_e.w));
                check("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.d));
                if (chk_lat) check("rsp_latency", 64'(cyc - mon_e.t), 64'd2);
                $display("rsp #%0d write=%0b rdata=0x%08h cycle=%0d", rsp_seen, rsp_write, rsp_rdata, cyc);
                last_rdata = rsp_rdata;
                rsp_seen++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request until accepted (bounded), scoring its response.
    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [W-1:0] d, input logic [W-1:0] m);
        bit   done;
        exp_t e;
        done      = 1'b0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_wmask = m;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (req_ready) begin
                check("mem_req", 64'(mem_req), 64'd1);
                check("mem_write", 64'(mem_write), 64'(w));
                check("mem_addr", 64'(mem_addr), 64'(a));
                check("mem_wdata", 64'(mem_wdata), 64'(d));
                check("mem_wmask", 64'(mem_wmask), 64'(m));
                e.w = w;
                e.t = cyc;
                if (w) begin
                    e.d = '0;
                    ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
                end else begin
                    e.d = suppress_rvalid ? '0 : ref_mem[a];
                end
                sb.push_back(e);
                $display("req write=%0b addr=%0d wdata=0x%08h wmask=0x%08h cycle=%0d", w, a, d, m, cyc);
                done = 1'b1;
            end
            tick();
        end
        check("issue_accepted", 64'(done), 64'd1);
        req_valid = 1'b0;
    endtask

    // Stream reads of addresses 16+s_idx until n accepted or max_cycles pass.
    task automatic stream(input int n, input int max_cycles);
        exp_t e;
        s_stalls = 0;
        for (int k = 0; k < max_cycles && s_idx < n; k++) begin
            req_valid = 1'b1;
            req_write = 1'b0;
            req_addr  = AW'(16 + s_idx);
            req_wdata = '0;
            req_wmask = '0;
            @(negedge clk);
            if (req_ready) begin
                e.w = 1'b0;
                e.d = ref_mem[16 + s_idx];
                e.t = cyc;
                sb.push_back(e);
                $display("req write=0 addr=%0d cycle=%0d", 16 + s_idx, cyc);
                s_idx++;
            end else begin
                s_stalls++;
            end
            tick();
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int n = 0; n < budget && !(sb.size() == 0 && idle); n++) tick();
        check("drained", 64'(sb.size() == 0 && idle), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    int base;

    initial begin
        // ---- reset state ----
        req_valid = 1'b1;
        #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_idle", 64'(idle), 64'd1);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_protocol_err", 64'(protocol_err), 64'd0);
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // ---- read after write ----
        chk_lat = 1'b1;
        base = rsp_seen;
        issue(1'b1, 7'd5, 32'hDEADBEEF, 32'hFFFFFFFF);
        issue(1'b0, 7'd5, 32'h0, 32'h0);
        wait_drain(20);
        check("raw_rsp_count", 64'(rsp_seen - base), 64'd2);
        check("raw_readback", 64'(last_rdata), 64'hDEADBEEF);

        // ---- masked write ----
        issue(1'b1, 7'd9, 32'hFFFFFFFF, 32'hFFFFFFFF);
        issue(1'b1, 7'd9, 32'h00000000, 32'h0000FFFF);
        issue(1'b0, 7'd9, 32'h0, 32'h0);
        wait_drain(20);
        check("masked_readback", 64'(last_rdata), 64'hFFFF0000);

        // ---- preload addresses 16..31 ----
        for (int i = 0; i < 16; i++)
            issue(1'b1, AW'(16 + i), 32'hA5000000 + 32'(i) * 32'h00010203, 32'hFFFFFFFF);
        wait_drain(20);

        // ---- back-to-back reads ----
        base  = rsp_seen;
        s_idx = 0;
        stream(16, 40);
        check("b2b_stalls", 64'(s_stalls), 64'd0);
        check("b2b_accepted", 64'(s_idx), 64'd16);
        wait_drain(20);
        check("b2b_rsp_count", 64'(rsp_seen - base), 64'd16);

        // ---- backpressure ----
        chk_lat   = 1'b0;
        rsp_ready = 1'b0;
        base      = rsp_seen;
        s_idx     = 0;
        stream(4, 8);
        check("bp_accepted_blocked", 64'(s_idx), 64'd2);
        check("bp_req_ready_low", 64'(req_ready), 64'd0);
        check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        rsp_ready = 1'b1;
        stream(4, 20);
        check("bp_accepted_total", 64'(s_idx), 64'd4);
        wait_drain(20);
        check("bp_rsp_count", 64'(rsp_seen - base), 64'd4);

        // ---- missing read return ----
        suppress_rvalid = 1'b1;
        issue(1'b0, 7'd5, 32'h0, 32'h0);
        tick();
        suppress_rvalid = 1'b0;
        wait_drain(20);
        check("missing_rdata_zero", 64'(last_rdata), 64'd0);
        check("missing_err", 64'(protocol_err), 64'd1);
        rst_n = 1'b0;
        #1;
        check("missing_err_reset", 64'(protocol_err), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // ---- spurious read return ----
        check("err_before", 64'(protocol_err), 64'd0);
        force_rvalid = 1'b1;
        @(negedge clk);
        check("err_same_cycle", 64'(protocol_err), 64'd0);
        tick();
        force_rvalid = 1'b0;
        @(negedge clk);
        check("err_next_cycle", 64'(protocol_err), 64'd1);
        repeat (3) tick();
        check("err_sticky", 64'(protocol_err), 64'd1);
        rst_n = 1'b0;
        #1;
        check("err_cleared", 64'(protocol_err), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("err_after_release", 64'(protocol_err), 64'd0);

        // ---- reset mid-stream ----
        rsp_ready = 1'b0;
        s_idx     = 0;
        stream(2, 6);
        tick();
        tick();
        check("mid_rsp_valid", 64'(rsp_valid), 64'd1);
        check("mid_idle", 64'(idle), 64'd0);
        base  = rsp_seen;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_idle", 64'(idle), 64'd1);
        check("mid_rst_req_ready", 64'(req_ready), 64'd1);
        sb.delete();
        tick();
        tick();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        repeat (6) tick();
        check("mid_no_stale_valid", 64'(rsp_valid), 64'd0);
        check("mid_no_stale_count", 64'(rsp_seen - base), 64'd0);
        check("final_idle", 64'(idle), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_prim_ram_1p_req_adapter

// File: doc/prim_ram_1p_req_adapter.md
PRIM_RAM_1P_REQ_ADAPTER -- requirements
Module: prim_ram_1p_req_adapter

Interface
REQ-001 Parameter Width, 32, data width in bits; Width SHALL match the attached single-port RAM.
REQ-002 Parameter Depth, 128, number of RAM words; Aw = $clog2(Depth).
REQ-003 Parameter RspDepth, 2, response queue entries; power of two, >= 2.
REQ-004 clk_i  input  1  sole clock, all state on its rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-006 req_valid_i  input  1  host request valid.
REQ-007 req_ready_o  output  1  adapter can accept a request this cycle.
REQ-008 req_write_i  input  1  1 = write, 0 = read.
REQ-009 req_addr_i  input  Aw  word address.
REQ-010 req_wdata_i  input  Width  write data.
REQ-011 req_wmask_i  input  Width  per-bit write enable.
REQ-012 rsp_valid_o  output  1  response available.
REQ-013 rsp_ready_i  input  1  host accepts response.
REQ-014 rsp_rdata_o  output  Width  read data; 0 for write acks.
REQ-015 rsp_write_o  output  1  response is a write ack.
REQ-016 mem_req_o, mem_write_o, mem_addr_o (Aw), mem_wdata_o (Width), mem_wmask_o (Width)  outputs  drive the RAM request port.
REQ-017 mem_rvalid_i  input  1 and mem_rdata_i  input  Width  RAM read return.
REQ-018 idle_o  output  1  no request in flight and queue empty.
REQ-019 protocol_err_o  output  1  sticky RAM-return protocol violation.

Function
REQ-020 Handshake: request accepted in a cycle iff req_valid_i & req_ready_o; req_* SHALL be ignored otherwise.
REQ-021 mem_req_o SHALL equal the accept condition combinationally; mem_write/addr/wdata/wmask SHALL pass req_* through unchanged.
REQ-022 One pending register (valid bit + write bit) SHALL be set on accept and cleared one cycle later when its response enters the queue.
REQ-023 RAM read latency is fixed at 1 cycle: a read accepted in cycle T SHALL push {rdata = mem_rdata_i, write = 0} at the end of T+1.
REQ-024 A write accepted in cycle T SHALL push {rdata = 0, write = 1} at the end of T+1.
REQ-025 Queue: FIFO of RspDepth entries; rsp_valid_o = (count != 0); pop on rsp_valid_o & rsp_ready_i; head SHALL hold stable while rsp_ready_i is low.
REQ-026 Minimum request-to-response latency SHALL be 2 cycles (accept T, rsp_valid_o at T+2).
REQ-027 req_ready_o = (count + pending - pop) < RspDepth; the queue SHALL never overflow.
REQ-028 Throughput: with rsp_ready_i held high, one request per cycle SHALL be sustained indefinitely.
REQ-029 Simultaneous push and pop SHALL leave count unchanged; when empty, simultaneous push and pop SHALL NOT occur (no bypass).
REQ-030 Read/write pointers SHALL wrap modulo RspDepth; count width = $clog2(RspDepth)+1.
REQ-031 Responses SHALL be returned in request order.
REQ-032 protocol_err_o SHALL set when mem_rvalid_i is high with no pending read, or low with a pending read, and SHALL hold until reset; on a missing read return, the pushed data SHALL be 0.
REQ-033 idle_o = !pending & (count == 0).

Reset
REQ-034 On rst_ni low: pending, count, pointers and protocol_err_o SHALL clear immediately; rsp_valid_o = 0, idle_o = 1, req_ready_o = 1 when req_valid_i is sampled.
REQ-035 Reset mid-operation SHALL discard in-flight and queued responses; none SHALL appear after release.
REQ-036 Queue data storage SHALL NOT require reset.

Structure
REQ-037 Shared package prim_ram_adapter_pkg SHALL hold the response entry typedef (rdata, write) and a RspDepth default constant.
REQ-038 The response queue SHALL be a single instance of prim_fifo_sync (Width+1 bits, depth RspDepth); pending tracking and error logic stay in the top.

Verification
REQ-039 Read after write: write addr 5 data 0xDEADBEEF mask all-ones, then read addr 5 -> write ack (rdata 0) then read rsp rdata 0xDEADBEEF, in order.
REQ-040 Back-to-back: 16 reads with rsp_ready_i = 1 -> req_ready_o never low, 16 responses on consecutive cycles, first at T+2.
REQ-041 Backpressure: rsp_ready_i = 0, issue 4 reads -> exactly 2 accepted (RspDepth=2), req_ready_o low; release -> remaining 2 accepted, all 4 responses correct, none lost or duplicated.
REQ-042 Masked write: write 0xFFFFFFFF, then wmask 0x0000FFFF data 0 -> readback 0xFFFF0000.
REQ-043 Protocol error: force mem_rvalid_i high with no read pending -> protocol_err_o high next cycle, stays high until rst_ni pulse.
REQ-044 Reset mid-stream: assert rst_ni with 2 queued responses -> rsp_valid_o low immediately, idle_o = 1, no stale response after release.
